// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period and the high time of a slow clock that is asynchronous
// to the 50 MHz board clock. The result is given in board-clock cycles. The
// block also flags a clock that has stopped (stall).
//
// The measured clock passes through a two-flop synchronizer and then one
// history flop. A rising edge is seen when the synchronized level is 1 and the
// history is 0. A falling edge is the opposite case.
//
// A single run counter measures the time since the last reference event. Each
// rising edge in MEASURE publishes the period and the latched high time.
//
// Parameters
//   CNT_W    width of all counters and of the count outputs
//   TIMEOUT  cycles without a rising edge before the clock counts as stalled.
//            Valid range: 8 <= TIMEOUT < 2**CNT_W.
//
// Ports
//   i_clock50    in   1      board clock; the only clock domain of this block
//   i_nReset     in   1      asynchronous active-low reset
//   i_measClk    in   1      clock under measurement (asynchronous)
//   o_periodCnt  out  CNT_W  last measured period, in i_clock50 cycles
//   o_highCnt    out  CNT_W  last measured high time, in i_clock50 cycles
//   o_valid      out  1      one-cycle pulse when both counts update
//   o_changed    out  1      pulses with o_valid when the period differs from
//                            the previous one, or on the first result after
//                            arming
//   o_stalled    out  1      level; set when no rising edge arrives in time,
//                            cleared by the next o_valid
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int          CNT_W   = 24,
    parameter int unsigned TIMEOUT = 24'hFFFFFF
) (
    input  logic             i_clock50,
    input  logic             i_nReset,
    input  logic             i_measClk,
    output logic [CNT_W-1:0] o_periodCnt,
    output logic [CNT_W-1:0] o_highCnt,
    output logic             o_valid,
    output logic             o_changed,
    output logic             o_stalled
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    // IDLE must not trust the synchronizer until its flops hold real samples.
    // Without this guard, a clock that is high at reset release looks low for
    // the first cycles (the flops reset to 0). IDLE would then arm on a false
    // edge.
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] runCnt_q, runCnt_d;
    logic [CNT_W-1:0] highLatch_q, highLatch_d;
    logic [CNT_W-1:0] periodCnt_q, periodCnt_d;
    logic [CNT_W-1:0] highCnt_q, highCnt_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             stalled_q, stalled_d;
    logic             first_q, first_d;

    logic             rise;
    logic             fall;
    logic             lvl_low;
    logic             settled;
    logic             reach_tmo;
    logic [CNT_W-1:0] run_sat;

    assign rise      = sync2_q & ~hist_q;
    assign fall      = ~sync2_q & hist_q;
    assign lvl_low   = ~sync2_q & ~hist_q;
    assign settled   = (runCnt_q >= SETTLE);
    // The timeout event is the cycle in which the counter would step onto
    // TIMEOUT. A rising edge in that same cycle restarts the counter first,
    // so the edge wins. For the same reason a period of exactly TIMEOUT can
    // never be published as a measurement.
    assign reach_tmo = (runCnt_q == TMO_M1);
    assign run_sat   = (runCnt_q == TMO) ? TMO : runCnt_q + ONE;

    always_comb begin
        state_d     = state_q;
        runCnt_d    = runCnt_q;
        highLatch_d = highLatch_q;
        periodCnt_d = periodCnt_q;
        highCnt_d   = highCnt_q;
        valid_d     = 1'b0;
        changed_d   = 1'b0;
        stalled_d   = stalled_q;
        first_d     = first_q;

        case (state_q)
            ST_IDLE: begin
                if (lvl_low && settled) begin
                    state_d  = ST_ARM;
                    runCnt_d = ONE;
                end else begin
                    runCnt_d = run_sat;
                    if (reach_tmo) begin
                        stalled_d = 1'b1;
                    end
                end
            end

            ST_ARM: begin
                if (rise) begin
                    state_d  = ST_MEASURE;
                    runCnt_d = ONE;
                    first_d  = 1'b1;
                end else begin
                    runCnt_d = run_sat;
                    if (reach_tmo) begin
                        stalled_d = 1'b1;
                    end
                end
            end

            ST_MEASURE: begin
                if (rise) begin
                    periodCnt_d = runCnt_q;
                    highCnt_d   = highLatch_q;
                    valid_d     = 1'b1;
                    changed_d   = first_q | (runCnt_q != periodCnt_q);
                    first_d     = 1'b0;
                    stalled_d   = 1'b0;
                    runCnt_d    = ONE;
                end else if (reach_tmo) begin
                    // Clock stopped: keep the published counts and start over.
                    stalled_d = 1'b1;
                    state_d   = ST_IDLE;
                    runCnt_d  = ONE;
                end else begin
                    runCnt_d = runCnt_q + ONE;
                    if (fall) begin
                        highLatch_d = runCnt_q;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                runCnt_d = ONE;
            end
        endcase
    end

    always_ff @(posedge i_clock50 or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            runCnt_q    <= '0;
            highLatch_q <= '0;
            periodCnt_q <= '0;
            highCnt_q   <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            stalled_q   <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= i_measClk;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            runCnt_q    <= runCnt_d;
            highLatch_q <= highLatch_d;
            periodCnt_q <= periodCnt_d;
            highCnt_q   <= highCnt_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            stalled_q   <= stalled_d;
            first_q     <= first_d;
        end
    end

    assign o_periodCnt = periodCnt_q;
    assign o_highCnt   = highCnt_q;
    assign o_valid     = valid_q;
    assign o_changed   = changed_q;
    assign o_stalled   = stalled_q;

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of an asynchronous, slowly generated development clock (e.g. the switchable 8.333 MHz / 8 Hz debug clock) in cycles of the 50 MHz board clock. It sits on the receiving side of the dev-chassis clock generator. Its counts, valid strobe and stall flag let the dev logic confirm which frequency setting is active and detect a stopped clock.

## Interface
- `CNT_W`, 24: width of all counters and measurement outputs.
- `TIMEOUT`, 24'hFFFFFF: cycles without a rising edge before the clock is declared stalled. Must be ≥ 8 and < 2^CNT_W.
- `i_clock50`  in  1  50 MHz board clock. Single clock domain.
- `i_nReset`  in  1  asynchronous, active-low reset.
- `i_measClk`  in  1  clock under measurement. Asynchronous to `i_clock50`.
- `o_periodCnt`  out  CNT_W  last measured period, in `i_clock50` cycles.
- `o_highCnt`  out  CNT_W  last measured high time, in `i_clock50` cycles.
- `o_valid`  out  1  one-cycle pulse when both counts update.
- `o_changed`  out  1  one-cycle pulse, coincident with `o_valid`, when the new `o_periodCnt` differs from the previous value.
- `o_stalled`  out  1  level. Set when no rising edge arrives within `TIMEOUT`.

## Operation
- Input path:
  - 2-flop synchronizer on `i_measClk`, followed by one history flop.
  - A rising edge is detected when `sync=1` and `hist=0`. A falling edge is detected when `sync=0` and `hist=1`.
- `runCnt` counts `i_clock50` cycles and saturates at `TIMEOUT`.
- State machine:
  - IDLE: wait for synchronized level 0, then go to ARM. This prevents a spurious first edge when `i_measClk` is high at reset release.
  - ARM: wait for a rising edge. On the edge, load `runCnt` ← 1 and go to MEASURE. No outputs update.
  - MEASURE, on a falling edge: `highLatch` ← `runCnt`.
  - MEASURE, on a rising edge:
    - `o_periodCnt` ← `runCnt`, `o_highCnt` ← `highLatch`.
    - Pulse `o_valid`.
    - Pulse `o_changed` if the new `o_periodCnt` differs from the old one, or if this is the first valid after ARM.
    - `runCnt` ← 1; stay in MEASURE.
  - MEASURE, otherwise: `runCnt` increments.
- Timeout:
  - `runCnt` also counts in IDLE and ARM, cleared to 1 on state entry.
  - When `runCnt == TIMEOUT` in any state: set `o_stalled`.
  - If in MEASURE: go to IDLE. Output counts hold their last values.
  - If in IDLE or ARM: stay put, `runCnt` holds at `TIMEOUT`.
- `o_stalled` clears on the cycle of the next `o_valid` pulse.
- Simultaneous events: timeout and a rising edge in the same cycle means the edge wins. The measurement is taken, `o_stalled` is not set, and the state stays MEASURE.
- Width: a period equal to `TIMEOUT` is reported as a stall, never as a measurement. The largest reportable period is `TIMEOUT`-1.
- Reset (async assert, any time including mid-measurement):
  - `o_periodCnt` = 0, `o_highCnt` = 0, `o_valid` = 0, `o_changed` = 0, `o_stalled` = 0.
  - State = IDLE, `runCnt` = 0, `highLatch` = 0, synchronizer and history flops = 0.
  - Synchronous release; the first update to `o_*` happens on the first `i_clock50` edge after deassertion.

## Timing
- Edge detection latency: 3 `i_clock50` edges after `i_measClk` is sampled changed (2 sync + history).
- Outputs, including `o_valid` and `o_changed`, are registered and update on the `i_clock50` edge following the detection cycle.
- First `o_valid` arrives at the second detected rising edge after entering ARM, i.e. one full `i_measClk` period after arming.
- Valid input range:
  - Each `i_measClk` phase must be ≥ 2 `i_clock50` cycles, so the period must be ≥ 4.
  - Shorter phases give undefined counts but must not lock up the FSM.
- Measurement resolution is ±1 cycle from synchronizer sampling. The bench uses input edges aligned away from `i_clock50` edges.

## Test plan
- Toggle `i_measClk` every 6 `i_clock50` cycles (period 12) → first `o_valid` with `o_periodCnt`=12, `o_highCnt`=6, `o_changed`=1. Each subsequent `o_valid` has `o_changed`=0.
- Asymmetric input, high 5 / low 7 cycles → `o_periodCnt`=12, `o_highCnt`=5. Then change to 5/9 → next `o_valid` has `o_periodCnt`=14, `o_changed`=1.
- `TIMEOUT`=100, run period 12, then hold `i_measClk` low → `o_stalled`=1 exactly 100 cycles after the last detected rising edge, counts hold at 12/6. Restart toggling → `o_stalled` clears with the next `o_valid`.
- `i_measClk` held high through reset release, then toggled at period 12 → no `o_valid` until a full low-high-low-high sequence. The first report is exactly 12.
- Assert `i_nReset` mid-period while in MEASURE → all outputs read 0 immediately (asynchronous). After release the first `o_valid` reports a full, correct period.
- Default `TIMEOUT`, input half-period 6,250,000 cycles → `o_periodCnt`=24'hBEBC20, `o_highCnt`=24'h5F5E10, `o_stalled`=0.
